// File: rtl/ss_seq_engine.sv
// Save-state initiator: walks the mapper save-state space to snapshot it into a
// buffer RAM (SAVE) or replays the buffer back into the mapper (LOAD).
`timescale 1ns/1ps
module ss_seq_engine #(
  parameter int SS_LEN  = 128,
  parameter int M2_HALF = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_save,
  input  logic       cmd_load,
  input  logic [7:0] map_idx_exp,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       ss_act,
  output logic       ss_we,
  output logic [7:0] ss_addr,
  output logic [7:0] ss_wdat,
  output logic       ss_m2,
  input  logic [7:0] ss_rdat,
  output logic [7:0] buf_addr,
  output logic       buf_we,
  output logic [7:0] buf_wdat,
  input  logic [7:0] buf_rdat
);

  localparam int SLOT_LEN = 2 * M2_HALF;
  localparam int SLOT_W   = $clog2(SLOT_LEN);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_LEN - 1);
  localparam logic [SLOT_W-1:0] M2_HI     = SLOT_W'(M2_HALF);
  localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);
  localparam logic [7:0] SAVE_LAST = 8'(SS_LEN - 1);
  localparam logic [7:0] LOAD_LAST = 8'(SS_LEN - 2);
  localparam logic [7:0] IDX_ADDR  = 8'(SS_LEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAVE,
    ST_LOAD_CHK,
    ST_LOAD,
    ST_FIN
  } state_t;

  state_t            state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [7:0]        addr_q, addr_d;
  logic [7:0]        wdat_q, wdat_d;
  logic              chk_q, chk_d;
  logic              err_q, err_d;
  logic              slot_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      slot_q  <= '0;
      addr_q  <= '0;
      wdat_q  <= '0;
      chk_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      chk_q   <= chk_d;
      err_q   <= err_d;
    end
  end

  assign slot_end = (slot_q == SLOT_LAST);

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    addr_d   = addr_q;
    wdat_d   = wdat_q;
    chk_d    = chk_q;
    err_d    = err_q;
    busy     = 1'b0;
    done     = 1'b0;
    ss_act   = 1'b0;
    ss_we    = 1'b0;
    ss_addr  = 8'h00;
    ss_wdat  = 8'h00;
    buf_addr = 8'h00;
    buf_we   = 1'b0;
    buf_wdat = 8'h00;

    case (state_q)
      ST_IDLE: begin
        if (cmd_save) begin
          state_d = ST_SAVE;
          addr_d  = 8'h00;
          slot_d  = '0;
          err_d   = 1'b0;
        end else if (cmd_load) begin
          state_d = ST_LOAD_CHK;
          chk_d   = 1'b0;
          err_d   = 1'b0;
        end
      end

      ST_SAVE: begin
        busy     = 1'b1;
        ss_act   = 1'b1;
        ss_addr  = addr_q;
        buf_addr = addr_q;
        slot_d   = slot_q + SLOT_ONE;
        // Capture mapper readback as late as possible in the slot.
        if (slot_end) begin
          buf_we   = 1'b1;
          buf_wdat = ss_rdat;
          slot_d   = '0;
          if (addr_q == SAVE_LAST) state_d = ST_FIN;
          else                     addr_d  = addr_q + 8'd1;
        end
      end

      ST_LOAD_CHK: begin
        busy = 1'b1;
        if (!chk_q) begin
          buf_addr = IDX_ADDR;
          chk_d    = 1'b1;
        end else begin
          // Prefetch entry 0 so slot 0 has data on its first cycle.
          buf_addr = 8'h00;
          chk_d    = 1'b0;
          addr_d   = 8'h00;
          slot_d   = '0;
          if (buf_rdat != map_idx_exp) begin
            err_d   = 1'b1;
            state_d = ST_FIN;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end

      ST_LOAD: begin
        busy    = 1'b1;
        ss_act  = 1'b1;
        ss_we   = 1'b1;
        ss_addr = addr_q;
        // Hold the slot's data even if the RAM output moves later in the slot.
        ss_wdat = (slot_q == '0) ? buf_rdat : wdat_q;
        if (slot_q == '0) wdat_d = buf_rdat;
        buf_addr = slot_end ? (addr_q + 8'd1) : addr_q;
        slot_d   = slot_q + SLOT_ONE;
        if (slot_end) begin
          slot_d = '0;
          if (addr_q == LOAD_LAST) state_d = ST_FIN;
          else                     addr_d  = addr_q + 8'd1;
        end
      end

      ST_FIN: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign ss_m2 = ss_act && (slot_q < M2_HI);
  assign err   = err_q;

endmodule

// File: tb/tb_ss_seq_engine.sv
// Directed bench for ss_seq_engine: table-driven SAVE/LOAD transactions plus
// hand-written reset, command-collision and short-slot sequences.
`timescale 1ns/1ps
module tb_ss_seq_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_save = 1'b0, cmd_load = 1'b0;
  logic [7:0] map_idx_exp = 8'd0;
  logic       busy, done, err, ss_act, ss_we, ss_m2, buf_we;
  logic [7:0] ss_addr, ss_wdat, ss_rdat, buf_addr, buf_wdat, buf_rdat;

  logic       cmd_save_s = 1'b0, cmd_load_s = 1'b0;
  logic [7:0] map_idx_exp_s = 8'd0;
  logic       busy_s, done_s, err_s, ss_act_s, ss_we_s, ss_m2_s, buf_we_s;
  logic [7:0] ss_addr_s, ss_wdat_s, ss_rdat_s, buf_addr_s, buf_wdat_s, buf_rdat_s;

  always #5 clk = ~clk;

  ss_seq_engine #(.SS_LEN(128), .M2_HALF(2)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_save(cmd_save), .cmd_load(cmd_load),
    .map_idx_exp(map_idx_exp), .busy(busy), .done(done), .err(err),
    .ss_act(ss_act), .ss_we(ss_we), .ss_addr(ss_addr), .ss_wdat(ss_wdat),
    .ss_m2(ss_m2), .ss_rdat(ss_rdat), .buf_addr(buf_addr), .buf_we(buf_we),
    .buf_wdat(buf_wdat), .buf_rdat(buf_rdat)
  );

  ss_seq_engine #(.SS_LEN(4), .M2_HALF(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .cmd_save(cmd_save_s), .cmd_load(cmd_load_s),
    .map_idx_exp(map_idx_exp_s), .busy(busy_s), .done(done_s), .err(err_s),
    .ss_act(ss_act_s), .ss_we(ss_we_s), .ss_addr(ss_addr_s), .ss_wdat(ss_wdat_s),
    .ss_m2(ss_m2_s), .ss_rdat(ss_rdat_s), .buf_addr(buf_addr_s), .buf_we(buf_we_s),
    .buf_wdat(buf_wdat_s), .buf_rdat(buf_rdat_s)
  );

  // Model mappers: readback is addr^0x5A, last address holds the map index.
  assign ss_rdat   = (ss_addr == 8'd127) ? 8'd44 : (ss_addr ^ 8'h5A);
  assign ss_rdat_s = (ss_addr_s == 8'd3) ? 8'h07 : (ss_addr_s ^ 8'h5A);

  // Snapshot RAMs with 1-clk read latency; big one has a bench preload port.
  logic [7:0] mem [256];
  logic [7:0] mem_s [256];
  logic       pre_we = 1'b0;
  logic [7:0] pre_addr = 8'd0, pre_dat = 8'd0;

  always @(posedge clk) begin
    if (pre_we)      mem[pre_addr] <= pre_dat;
    else if (buf_we) mem[buf_addr] <= buf_wdat;
    buf_rdat <= mem[buf_addr];
  end

  always @(posedge clk) begin
    if (buf_we_s) mem_s[buf_addr_s] <= buf_wdat_s;
    buf_rdat_s <= mem_s[buf_addr_s];
  end

  // Mapper write capture on the falling edge of ss_m2.
  logic [7:0] mlog [256];
  int mwr_cnt = 0;
  always @(negedge ss_m2) begin
    if (ss_we) begin
      mlog[ss_addr] <= ss_wdat;
      mwr_cnt       <= mwr_cnt + 1;
    end
  end

  int sfall_cnt = 0, sfall_bad = 0;
  always @(negedge ss_m2_s) begin
    if (ss_addr_s != 8'(sfall_cnt) || ss_we_s) sfall_bad <= sfall_bad + 1;
    sfall_cnt <= sfall_cnt + 1;
  end

  int we_cyc = 0, bufwe_cyc = 0, act_cyc = 0, done_cnt = 0, bufwe_s_cyc = 0;
  always @(negedge clk) begin
    if (ss_we)    we_cyc      <= we_cyc + 1;
    if (buf_we)   bufwe_cyc   <= bufwe_cyc + 1;
    if (ss_act)   act_cyc     <= act_cyc + 1;
    if (done)     done_cnt    <= done_cnt + 1;
    if (buf_we_s) bufwe_s_cyc <= bufwe_s_cyc + 1;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic preload_ramp(input logic [7:0] idx);
    for (int k = 0; k < 128; k++) begin
      @(negedge clk);
      pre_we   = 1'b1;
      pre_addr = k[7:0];
      pre_dat  = (k == 127) ? idx : 8'(k + 1);
    end
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // op: 0 save, 1 load, 2 both pulses together. lat=-1 on timeout.
  task automatic run_cmd(input int op, output int lat);
    bit seen;
    seen = 1'b0;
    lat  = 0;
    @(negedge clk);
    cmd_save = (op != 1);
    cmd_load = (op != 0);
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      cmd_save = 1'b0;
      cmd_load = 1'b0;
      lat++;
      if (done) seen = 1'b1;
    end
    if (!seen) lat = -1;
  endtask

  typedef struct {
    int         op;
    int         pre;
    logic [7:0] pre_idx;
    logic [7:0] exp_idx;
    int         lat;
    int         err;
    int         bufwe;
    int         wecyc;
    int         mwr;
    int         act;
    int         chk_buf;
    int         chk_map;
  } vec_t;

  vec_t tbl [4];

  initial begin
    int lat, b_we, b_bufwe, b_act, b_done, b_mwr, bad, found;

    tbl[0] = '{0, 0, 8'd0,  8'd0,  513, 0, 128, 0,   0,   512, 1, 0};
    tbl[1] = '{1, 1, 8'd44, 8'd44, 511, 0, 0,   508, 127, 508, 0, 1};
    tbl[2] = '{1, 1, 8'd4,  8'd44, 3,   1, 0,   0,   0,   0,   0, 0};
    tbl[3] = '{2, 0, 8'd0,  8'd44, 513, 0, 128, 0,   0,   512, 1, 0};

    // Reset state
    #23;
    chk("rst_flags", int'({busy, done, err, ss_act, ss_we, ss_m2, buf_we}), 0);
    chk("rst_ss_addr", int'(ss_addr), 0);
    chk("rst_buf_addr", int'(buf_addr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int t = 0; t < 4; t++) begin
      if (tbl[t].pre != 0) preload_ramp(tbl[t].pre_idx);
      map_idx_exp = tbl[t].exp_idx;
      b_we = we_cyc; b_bufwe = bufwe_cyc; b_act = act_cyc; b_done = done_cnt; b_mwr = mwr_cnt;
      run_cmd(tbl[t].op, lat);
      chk($sformatf("t%0d_latency", t), lat, tbl[t].lat);
      chk($sformatf("t%0d_err", t), int'(err), tbl[t].err);
      chk($sformatf("t%0d_busy_at_done", t), int'(busy), 0);
      repeat (4) @(negedge clk);
      chk($sformatf("t%0d_done_pulses", t), done_cnt - b_done, 1);
      chk($sformatf("t%0d_buf_we_cycles", t), bufwe_cyc - b_bufwe, tbl[t].bufwe);
      chk($sformatf("t%0d_ss_we_cycles", t), we_cyc - b_we, tbl[t].wecyc);
      chk($sformatf("t%0d_mapper_writes", t), mwr_cnt - b_mwr, tbl[t].mwr);
      chk($sformatf("t%0d_ss_act_cycles", t), act_cyc - b_act, tbl[t].act);
      chk($sformatf("t%0d_err_held", t), int'(err), tbl[t].err);
      if (tbl[t].chk_buf != 0) begin
        bad = 0;
        for (int k = 0; k < 128; k++)
          if (mem[k] != ((k == 127) ? 8'd44 : (8'(k) ^ 8'h5A))) bad++;
        chk($sformatf("t%0d_buf3", t), int'(mem[3]), 'h59);
        chk($sformatf("t%0d_buf127", t), int'(mem[127]), 44);
        chk($sformatf("t%0d_buf_bad_entries", t), bad, 0);
      end
      if (tbl[t].chk_map != 0) begin
        bad = 0;
        for (int k = 0; k < 127; k++)
          if (mlog[k] != 8'(k + 1)) bad++;
        chk($sformatf("t%0d_mapper_bad_entries", t), bad, 0);
      end
      $display("txn %0d op=%0d latency=%0d err=%0d buf_we=%0d mapper_writes=%0d",
               t, tbl[t].op, lat, err, bufwe_cyc - b_bufwe, mwr_cnt - b_mwr);
    end

    // Reset during LOAD slot 40 (buffer holds a fresh save with idx 44).
    map_idx_exp = 8'd44;
    b_done = done_cnt;
    @(negedge clk);
    cmd_load = 1'b1;
    @(negedge clk);
    cmd_load = 1'b0;
    found = 0;
    for (int i = 0; i < 1000 && found == 0; i++) begin
      @(negedge clk);
      if (ss_we && ss_addr == 8'd40) found = 1;
    end
    chk("rst_mid_reached_slot40", found, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", int'({ss_act, ss_we, busy, ss_m2}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("rst_mid_no_done", done_cnt - b_done, 0);
    chk("rst_mid_idle", int'({busy, ss_act, err}), 0);
    $display("txn rst_mid_load found_slot40=%0d done_pulses=%0d", found, done_cnt - b_done);

    // cmd_load pulsed mid-save is ignored.
    b_done = done_cnt; b_we = we_cyc;
    lat = 0; found = 0;
    @(negedge clk);
    cmd_save = 1'b1;
    for (int i = 0; i < 2000 && found == 0; i++) begin
      @(negedge clk);
      cmd_save = 1'b0;
      cmd_load = (lat == 49);
      lat++;
      if (done) found = 1;
    end
    cmd_load = 1'b0;
    if (found == 0) lat = -1;
    repeat (20) @(negedge clk);
    chk("midsave_latency", lat, 513);
    chk("midsave_done_pulses", done_cnt - b_done, 1);
    chk("midsave_ss_we_cycles", we_cyc - b_we, 0);
    $display("txn save_with_load_pulse latency=%0d done_pulses=%0d", lat, done_cnt - b_done);

    // Short slot instance: M2_HALF=1, SS_LEN=4.
    lat = 0; found = 0;
    b_bufwe = bufwe_s_cyc;
    @(negedge clk);
    cmd_save_s = 1'b1;
    for (int i = 0; i < 100 && found == 0; i++) begin
      @(negedge clk);
      cmd_save_s = 1'b0;
      lat++;
      if (done_s) found = 1;
    end
    if (found == 0) lat = -1;
    repeat (3) @(negedge clk);
    chk("short_latency", lat, 9);
    chk("short_m2_falls", sfall_cnt, 4);
    chk("short_addr_unstable_falls", sfall_bad, 0);
    chk("short_buf_we_cycles", bufwe_s_cyc - b_bufwe, 4);
    chk("short_buf0", int'(mem_s[0]), 'h5A);
    chk("short_buf3", int'(mem_s[3]), 'h07);
    $display("txn short_save latency=%0d falls=%0d", lat, sfall_cnt);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ss_seq_engine.md
Name: ss_seq_engine

Overview:
- Initiator side of the mapper save-state port. Mapper modules only answer `ss_addr`/`ss_we`/`ss_rdat`; this block drives them.
- SAVE: walks every save-state address, samples `ss_rdat` and stores it to a snapshot buffer RAM.
- LOAD: checks the stored map index, then replays the buffer into the mapper as save-state writes.
- Sits between the system controller (command/status) and the active mapper. It also generates the `ss_m2` strobe; mappers latch save-state writes on its falling edge.

Parameters:
- SS_LEN, 128, number of save-state addresses walked (0..SS_LEN-1); the last address holds map_idx and is read-only.
- M2_HALF, 2, clk cycles per `ss_m2` half-period (≥1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_save  in  1  single-cycle pulse: start SAVE
- cmd_load  in  1  single-cycle pulse: start LOAD
- map_idx_exp  in  8  index of the currently loaded mapper
- busy  out  1  operation in progress
- done  out  1  single-cycle pulse: operation finished
- err  out  1  load aborted on map_idx mismatch; held until next command
- ss_act  out  1  save-state access active (mapper ignores CPU bus)
- ss_we  out  1  save-state write strobe
- ss_addr  out  8  save-state register address
- ss_wdat  out  8  write data (driven onto mapper cpu_dat path)
- ss_m2  out  1  save-state clock to mapper
- ss_rdat  in  8  mapper readback, combinational from ss_addr
- buf_addr  out  8  snapshot RAM address
- buf_we  out  1  snapshot RAM write enable
- buf_wdat  out  8  snapshot RAM write data
- buf_rdat  in  8  snapshot RAM read data, 1 clk latency

Behaviour:
- Reset (async, rst_n=0): all outputs 0, FSM to IDLE. This is immediate even mid-operation.
  - `ss_act` drops at once and no further `ss_we` is issued.
  - A partially loaded mapper is left as-is; recovery is the controller's job.
- States: IDLE, SAVE, LOAD_CHK, LOAD, FIN.
- IDLE:
  - `cmd_save` → SAVE; `cmd_load` → LOAD_CHK.
  - Both in the same cycle: SAVE wins.
  - Starting either command clears `err`.
  - Commands while busy=1 are ignored.
- Slot timing:
  - One slot = 2*M2_HALF clk.
  - `ss_m2` is high for the first M2_HALF clk of a slot and low for the rest.
  - `ss_addr`, `ss_wdat` and `ss_we` change only at slot start, so they are stable across the `ss_m2` falling edge.
  - `ss_m2` is 0 whenever `ss_act`=0.
- SAVE:
  - Cycle after `cmd_save`: busy=1, `ss_act`=1, slot 0 starts with ss_addr=0.
  - In the last clk of each slot: buf_we=1, buf_addr=ss_addr, buf_wdat=ss_rdat.
  - ss_addr increments per slot, 0..SS_LEN-1; `ss_we` stays 0 throughout.
  - After the last slot → FIN.
- LOAD_CHK:
  - busy=1, `ss_act`=0, buf_addr=SS_LEN-1; wait 1 clk for read data.
  - buf_rdat≠map_idx_exp → err=1, → FIN with no ss_we ever asserted.
  - Match → LOAD.
- LOAD:
  - `ss_act`=1. For k=0..SS_LEN-2: buf_addr=k is presented 1 clk before slot k.
  - Slot k: ss_addr=k, ss_wdat=buf_rdat, ss_we=1 for the whole slot.
  - Address SS_LEN-1 is never written.
- FIN (1 clk): done=1, busy=0, ss_act=0, ss_we=0, ss_addr=0 → IDLE.
- Latency:
  - SAVE: done exactly 1 + SS_LEN*2*M2_HALF clk after the `cmd_save` cycle.
  - LOAD OK: done at 2 + 1 + (SS_LEN-1)*2*M2_HALF clk after the `cmd_load` cycle.
  - LOAD mismatch: done at 3 clk after the `cmd_load` cycle.
- Widths:
  - ss_addr counter is 8 bits; SS_LEN ≤ 256, and SS_LEN=256 terminates on the count, not on wrap.
  - Slot counter is ceil(log2(2*M2_HALF)) bits and wraps to 0 at slot end.
- buf_we is never asserted outside SAVE.

Test Plan:
- SAVE, M2_HALF=2, SS_LEN=128, model mapper returns ss_rdat=addr^0x5A, map_idx=44 at 127 → 128 buffer writes, buf[127]=44, buf[3]=0x59, done at clk 513, ss_we never 1.
- LOAD with buf[127]=44, map_idx_exp=44, buf[k]=k+1 → 127 ss_we slots; mapper sees (addr 0,data 1) … (126,127) on ss_m2 falling edges; done at clk 511, err=0.
- LOAD with buf[127]=4, map_idx_exp=44 → err=1, done at clk 3, ss_act never 1, zero ss_we.
- cmd_save and cmd_load in the same cycle → SAVE runs. cmd_load pulsed mid-save → ignored, a single done only.
- rst_n low during LOAD slot 40 → ss_act/ss_we/busy/ss_m2 = 0 immediately. After release: IDLE, no done pulse, err=0.
- M2_HALF=1, SS_LEN=4 → slot is 2 clk, ss_m2 toggles every clk, SAVE done at clk 9; ss_addr stable across each falling edge.
